// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: single-outstanding AHB-Lite initiator.
// Turns a valid/ready command into one NONSEQ SINGLE transfer and reports
// completion on a one-cycle response strobe.
// Optional build macro AHB_LITE_CMD_MASTER_TIMEOUT_EN adds a sticky
// stall-timeout flag; without it timeout_flag is tied low.
module ahb_lite_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              timeout_flag
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_REJ  = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] haddr_r, haddr_s;
    logic [1:0]        htrans_r, htrans_s;
    logic              hwrite_r, hwrite_s;
    logic [2:0]        hsize_r, hsize_s;
    logic [DATA_W-1:0] hwdata_r, hwdata_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic              rsp_err_r, rsp_err_s;
    logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;

    // Size/alignment legality: bytes anywhere, halfwords even, words 4-aligned.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lo[0] == 1'b0);
            3'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state and next-output decode; registered values hold by default.
    always_comb begin
        state_s     = state_r;
        haddr_s     = haddr_r;
        htrans_s    = htrans_r;
        hwrite_s    = hwrite_r;
        hsize_s     = hsize_r;
        hwdata_s    = hwdata_r;
        wdata_s     = wdata_r;
        rsp_valid_s = 1'b0;
        rsp_err_s   = rsp_err_r;
        rsp_rdata_s = rsp_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        haddr_s  = cmd_addr;
                        hwrite_s = cmd_write;
                        hsize_s  = cmd_size;
                        wdata_s  = cmd_wdata;
                        htrans_s = HTRANS_NONSEQ;
                        state_s  = ST_ADDR;
                    end else begin
                        state_s = ST_REJ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // Control stays frozen until the address phase is accepted.
                if (HREADY) begin
                    htrans_s = HTRANS_IDLE;
                    if (hwrite_r) begin
                        hwdata_s = wdata_r;
                    end else begin
                        hwdata_s = hwdata_r;
                    end
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                // First ERROR cycle has HREADY low and is simply waited out.
                if (HREADY) begin
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = (HRESP != 2'b00);
                    if (hwrite_r) begin
                        rsp_rdata_s = {DATA_W{1'b0}};
                    end else begin
                        rsp_rdata_s = HRDATA;
                    end
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_REJ: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
                rsp_rdata_s = {DATA_W{1'b0}};
                state_s     = ST_IDLE;
            end
            default: begin
                htrans_s = HTRANS_IDLE;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= ST_IDLE;
            haddr_r     <= {ADDR_W{1'b0}};
            htrans_r    <= HTRANS_IDLE;
            hwrite_r    <= 1'b0;
            hsize_r     <= 3'b000;
            hwdata_r    <= {DATA_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            haddr_r     <= haddr_s;
            htrans_r    <= htrans_s;
            hwrite_r    <= hwrite_s;
            hsize_r     <= hsize_s;
            hwdata_r    <= hwdata_s;
            wdata_r     <= wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
        end
    end

`ifdef AHB_LITE_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_r, to_cnt_s;
    logic        to_flag_r, to_flag_s;
    logic        stall_s;

    assign stall_s = ((state_r == ST_ADDR) || (state_r == ST_DATA)) && !HREADY;

    // Stall counter restarts on each state change; flag latches once the limit is hit while stalled.
    always_comb begin
        to_cnt_s  = to_cnt_r;
        to_flag_s = to_flag_r;
        if (state_s != state_r) begin
            to_cnt_s = 16'd0;
        end else if (stall_s && (to_cnt_r != 16'hFFFF)) begin
            to_cnt_s = to_cnt_r + 16'd1;
        end else begin
            to_cnt_s = to_cnt_r;
        end
        if (stall_s && (to_cnt_r >= TO_LIMIT)) begin
            to_flag_s = 1'b1;
        end else begin
            to_flag_s = to_flag_r;
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            to_cnt_r  <= 16'd0;
            to_flag_r <= 1'b0;
        end else begin
            to_cnt_r  <= to_cnt_s;
            to_flag_r <= to_flag_s;
        end
    end

    assign timeout_flag = to_flag_r;
`else
    assign timeout_flag = 1'b0;
`endif

    assign cmd_ready = (state_r == ST_IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign HADDR     = haddr_r;
    assign HTRANS    = htrans_r;
    assign HWRITE    = hwrite_r;
    assign HSIZE     = hsize_r;
    assign HWDATA    = hwdata_r;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Testbench for ahb_lite_cmd_master: scripted AHB slave, response scoreboard,
// directed cases followed by randomized commands.
module tb_ahb_lite_cmd_master;

`ifdef AHB_LITE_CMD_MASTER_TIMEOUT_EN
    localparam int TO_CYC = 8;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO_CYC = 1024;
    localparam bit TO_EN  = 1'b0;
`endif

    logic        HCLK, HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HMASTLOCK, HREADY, timeout_flag;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    ahb_lite_cmd_master #(
        .ADDR_W(32), .DATA_W(32), .HPROT_VAL(4'b0011), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .timeout_flag(timeout_flag)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dw;
        bit          err;
        logic [1:0]  fin;
    } xfer_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    xfer_t scr_q[$];
    rsp_t  exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check32("rst_HTRANS", HTRANS, 32'd0);
        check32("rst_HADDR", HADDR, 32'd0);
        check32("rst_HWRITE", HWRITE, 32'd0);
        check32("rst_HSIZE", HSIZE, 32'd0);
        check32("rst_HWDATA", HWDATA, 32'd0);
        check32("rst_rsp_valid", rsp_valid, 32'd0);
        check32("rst_rsp_err", rsp_err, 32'd0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check32("rst_timeout_flag", timeout_flag, 32'd0);
        check32("rst_cmd_ready", cmd_ready, 32'd1);
    endtask

    // Scripted slave: follows the bus from the observed NONSEQ, inserts the
    // requested wait states and checks the master's bus behaviour.
    initial begin
        xfer_t cur;
        int    ph;
        int    cnt;
        ph = 0;
        cnt = 0;
        HREADY = 1'b1;
        HRESP = 2'b00;
        HRDATA = 32'd0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                ph = 0;
                HREADY = 1'b1;
                HRESP = 2'b00;
            end else begin
                if (ph == 0) begin
                    HREADY = 1'b1;
                    HRESP = 2'b00;
                    HRDATA = $urandom;
                    if (HTRANS != 2'b00) begin
                        if (HTRANS == 2'b10 && scr_q.size() > 0) begin
                            cur = scr_q.pop_front();
                            ph = 1;
                            cnt = cur.aw;
                            check32("HBURST", HBURST, 32'd0);
                            check32("HPROT", HPROT, 32'd3);
                            check32("HMASTLOCK", HMASTLOCK, 32'd0);
                        end else begin
                            check32("spurious_HTRANS", HTRANS, 32'd0);
                        end
                    end
                end
                if (ph == 1) begin
                    check32("addr_HTRANS", HTRANS, 32'd2);
                    check32("addr_HADDR", HADDR, cur.addr);
                    check32("addr_HWRITE", HWRITE, cur.wr);
                    check32("addr_HSIZE", HSIZE, cur.size);
                    HRESP = 2'b00;
                    HRDATA = $urandom;
                    if (cnt > 0) begin
                        HREADY = 1'b0;
                        cnt--;
                    end else begin
                        HREADY = 1'b1;
                        ph = 2;
                        cnt = cur.dw;
                    end
                end else if (ph == 2) begin
                    check32("data_HTRANS", HTRANS, 32'd0);
                    if (cur.wr) check32("data_HWDATA", HWDATA, cur.wdata);
                    if (cnt > 0) begin
                        HREADY = 1'b0;
                        HRESP = (cur.err && cnt == 1) ? 2'b01 : 2'b00;
                        HRDATA = $urandom;
                        cnt--;
                    end else begin
                        HREADY = 1'b1;
                        HRESP = cur.err ? cur.fin : 2'b00;
                        HRDATA = cur.rdata;
                        ph = 0;
                    end
                end
            end
        end
    end

    // Response monitor: every strobe must match the oldest expected response.
    initial begin
        rsp_t e;
        forever begin
            @(negedge HCLK);
            if (!HRESET && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check32("unexpected_rsp_valid", rsp_valid, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check32("rsp_err", rsp_err, e.err);
                    check32("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    // Issue one command from a negedge; optionally wait for and time its response.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int aw, input int dw, input bit err, input bit want_rsp);
        bit    legal;
        xfer_t x;
        rsp_t  r;
        int    exp_lat;
        int    lat;
        int    pick;
        legal = (size == 3'd0) || (size == 3'd1 && addr % 2 == 0) || (size == 3'd2 && addr % 4 == 0);
        if (err && dw < 1) dw = 1;
        pick = $urandom_range(0, 2);
        x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata; x.rdata = rdata;
        x.aw = aw; x.dw = dw; x.err = err;
        x.fin = (pick == 0) ? 2'b01 : ((pick == 1) ? 2'b10 : 2'b11);
        if (legal) scr_q.push_back(x);
        r.err = legal ? err : 1'b1;
        r.rdata = (legal && !wr) ? rdata : 32'd0;
        if (want_rsp) exp_q.push_back(r);
        exp_lat = legal ? (aw + dw + 3) : 2;
        cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
        cmd_valid = 1'b1;
        check32("cmd_ready_idle", cmd_ready, 32'd1);
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_size = 3'($urandom); cmd_wdata = $urandom;
        check32("cmd_ready_busy", cmd_ready, 32'd0);
        check32("HTRANS_after_accept", HTRANS, legal ? 32'd2 : 32'd0);
        if (want_rsp) begin
            lat = 0;
            for (int i = 1; i <= 64; i++) begin
                @(negedge HCLK);
                if (rsp_valid) begin
                    lat = i;
                    break;
                end
            end
            check32("rsp_latency", lat, exp_lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_size = 3'd0; cmd_wdata = 32'd0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_reset_vals();
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);

        // Directed cases
        issue(1'b0, 32'h2000_0004, 3'd2, 32'd0, 32'hDEADBEEF, 0, 0, 1'b0, 1'b1);
        issue(1'b1, 32'h2000_0100, 3'd2, 32'h1234_5678, 32'h5555_AAAA, 0, 3, 1'b0, 1'b1);
        issue(1'b0, 32'h2000_0200, 3'd2, 32'd0, 32'hCAFE_F00D, 0, 1, 1'b1, 1'b1);
        issue(1'b1, 32'h3000_0010, 3'd1, 32'h0000_BEEF, 32'd0, 4, 0, 1'b0, 1'b1);
        issue(1'b0, 32'h2000_0002, 3'd2, 32'd0, 32'h1111_1111, 0, 0, 1'b0, 1'b1);
        issue(1'b1, 32'h2000_0003, 3'd1, 32'h2222_2222, 32'd0, 0, 0, 1'b0, 1'b1);
        issue(1'b0, 32'h2000_0000, 3'd3, 32'd0, 32'h3333_3333, 0, 0, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 3'd0, 32'd0, 32'h0000_00A5, 2, 2, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0006, 3'd1, 32'h0000_7E7E, 32'd0, 1, 2, 1'b1, 1'b1);

        // Reset in the middle of a stalled write data phase: no response expected.
        issue(1'b1, 32'h4000_0000, 3'd2, 32'hA5A5_5A5A, 32'd0, 0, 6, 1'b0, 1'b0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        check_reset_vals();
        for (int i = 0; i < 8; i++) begin
            @(negedge HCLK);
            check32("no_rsp_after_reset", rsp_valid, 32'd0);
        end

        // Randomized commands
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge HCLK);
            a = $urandom;
            issue(1'($urandom), a, 3'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Long data-phase stall: flag only exists in the timeout build.
        check32("timeout_flag_before", timeout_flag, 32'd0);
        issue(1'b0, 32'h5000_0000, 3'd2, 32'd0, 32'h0BAD_CAFE, 0, 10, 1'b0, 1'b1);
        repeat (2) @(negedge HCLK);
        check32("timeout_flag_after", timeout_flag, {31'd0, TO_EN});
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        check_reset_vals();

        repeat (5) @(negedge HCLK);
        check32("exp_q_drained", exp_q.size(), 32'd0);
        check32("scr_q_drained", scr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
